// File: rtl/dds_sweep_ctrl_if.sv
// Control/status bundle between the register block and the DDS sweep sequencer.
// The master drives sweep configuration; the slave returns the frequency word and status.
interface dds_sweep_ctrl_if #(
    parameter int FW = 16,
    parameter int DW = 16
);
    logic          start;
    logic          abort;
    logic [1:0]    mode;
    logic [FW-1:0] f_start;
    logic [FW-1:0] f_stop;
    logic [FW-1:0] f_step;
    logic [DW-1:0] dwell;
    logic [FW-1:0] freq_cntrl;
    logic          busy;
    logic          done;
    logic          dir;

    modport master (
        output start, abort, mode, f_start, f_stop, f_step, dwell,
        input  freq_cntrl, busy, done, dir
    );

    modport slave (
        input  start, abort, mode, f_start, f_stop, f_step, dwell,
        output freq_cntrl, busy, done, dir
    );
endinterface

// File: rtl/dds_sweep_ctrl.sv
// Frequency-sweep sequencer feeding the DDS phase accumulator's frequency control word.
// Steps linearly from start to stop word with a per-word dwell; single, sawtooth and triangle modes.
module dds_sweep_ctrl #(
    parameter int FW = 16,
    parameter int DW = 16
) (
    input  logic             clk,
    input  logic             res_n,
    dds_sweep_ctrl_if.slave  sw
);

    typedef enum logic {IDLE, HOLD} state_e;

    state_e        state_q, state_d;
    logic [FW-1:0] freq_q, freq_d;
    logic [FW-1:0] target_q, target_d;
    logic [FW-1:0] origin_q, origin_d;
    logic [FW-1:0] step_q, step_d;
    logic [DW-1:0] dwell_q, dwell_d;
    logic [DW-1:0] cnt_q, cnt_d;
    logic [1:0]    mode_q, mode_d;
    logic          dir_q, dir_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    // One step toward tgt in FW+1 bits; reaching or crossing tgt (carry/borrow included) clamps to it.
    function automatic logic [FW-1:0] stepToward(input logic [FW-1:0] cur,
                                                 input logic [FW-1:0] tgt,
                                                 input logic [FW-1:0] stp,
                                                 input logic          up);
        logic [FW:0]   sum;
        logic [FW-1:0] res;
        sum = '0;
        res = tgt;
        if (stp != '0) begin
            if (up) begin
                sum = {1'b0, cur} + {1'b0, stp};
                if (sum < {1'b0, tgt}) res = sum[FW-1:0];
            end else begin
                sum = {1'b0, cur} - {1'b0, stp};
                if (!sum[FW] && (sum[FW-1:0] > tgt)) res = sum[FW-1:0];
            end
        end
        return res;
    endfunction

    always_comb begin
        state_d  = state_q;
        freq_d   = freq_q;
        target_d = target_q;
        origin_d = origin_q;
        step_d   = step_q;
        dwell_d  = dwell_q;
        cnt_d    = cnt_q;
        mode_d   = mode_q;
        dir_d    = dir_q;
        busy_d   = busy_q;
        done_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (sw.start && !sw.abort) begin
                    mode_d   = sw.mode;
                    step_d   = sw.f_step;
                    dwell_d  = sw.dwell;
                    target_d = sw.f_stop;
                    origin_d = sw.f_start;
                    freq_d   = sw.f_start;
                    cnt_d    = sw.dwell;
                    dir_d    = (sw.f_stop >= sw.f_start);
                    busy_d   = 1'b1;
                    state_d  = HOLD;
                end
            end
            HOLD: begin
                if (sw.abort) begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - DW'(1);
                end else if (freq_q != target_q) begin
                    freq_d = stepToward(freq_q, target_q, step_q, dir_q);
                    cnt_d  = dwell_q;
                end else begin
                    // End of leg: mode 3 behaves as single sweep.
                    unique case (mode_q)
                        2'd1: begin
                            freq_d = origin_q;
                            cnt_d  = dwell_q;
                        end
                        2'd2: begin
                            target_d = origin_q;
                            origin_d = target_q;
                            dir_d    = ~dir_q;
                            freq_d   = stepToward(freq_q, origin_q, step_q, ~dir_q);
                            cnt_d    = dwell_q;
                        end
                        default: begin
                            done_d  = 1'b1;
                            busy_d  = 1'b0;
                            state_d = IDLE;
                        end
                    endcase
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            state_q  <= IDLE;
            freq_q   <= '0;
            target_q <= '0;
            origin_q <= '0;
            step_q   <= '0;
            dwell_q  <= '0;
            cnt_q    <= '0;
            mode_q   <= 2'd0;
            dir_q    <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            freq_q   <= freq_d;
            target_q <= target_d;
            origin_q <= origin_d;
            step_q   <= step_d;
            dwell_q  <= dwell_d;
            cnt_q    <= cnt_d;
            mode_q   <= mode_d;
            dir_q    <= dir_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign sw.freq_cntrl = freq_q;
    assign sw.busy       = busy_q;
    assign sw.done       = done_q;
    assign sw.dir        = dir_q;

endmodule
